// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects, the load
// result-source encoding and the memory-wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Per-operand EX forwarding select: memory stage wins over writeback, and
// register 0 is never forwarded.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] sel
);

  fwd_sel_e sel_e;

  always_comb begin
    sel_e = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
      sel_e = FWD_M;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
      sel_e = FWD_W;
  end

  assign sel = sel_e;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use/branch stall-flush and a watchdog-
// guarded data-memory wait FSM. HAZARD_PERF_EN adds stall/flush counters.
//
// state    | meaning
// RUN      | normal flow; load-use and branch rules apply
// MEM_WAIT | data memory busy; whole pipe held until mem_ready or watchdog
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int TO_WIDTH    = 8,
  parameter int MEM_TIMEOUT = 200
`ifdef HAZARD_PERF_EN
  ,
  parameter int DATA_WIDTH  = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            rs1D,
  input  logic [4:0]            rs2D,
  input  logic [4:0]            rs1E,
  input  logic [4:0]            rs2E,
  input  logic [4:0]            RdE,
  input  logic [4:0]            RdM,
  input  logic [4:0]            RdW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  MemAccessM,
  input  logic                  mem_ready,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallPC,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushF,
  output logic                  FlushD,
`ifdef HAZARD_PERF_EN
  output logic [DATA_WIDTH-1:0] stall_cycles,
  output logic [DATA_WIDTH-1:0] flush_events,
`endif
  output logic                  mem_timeout
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(MEM_TIMEOUT - 1);

  hz_state_e           state;
  logic [TO_WIDTH-1:0] wd_cnt;
  logic                lu;
  logic                to_release;
  logic                mw;

  forward_sel u_fwd_a (
    .rs          (rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (ForwardAE)
  );

  forward_sel u_fwd_b (
    .rs          (rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (ForwardBE)
  );

  // Release cycles (mem_ready or watchdog) drop the wait stall in the same
  // cycle so a branch or load-use held in E can act immediately.
  always_comb begin
    lu         = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                 ((RdE == rs1D) || (RdE == rs2D));
    to_release = (state == MEM_WAIT) && !mem_ready && (wd_cnt == TO_LAST);
    mw         = ((state == MEM_WAIT) || MemAccessM) && !mem_ready && !to_release;

    StallPC = 1'b0;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushF  = 1'b0;
    FlushD  = 1'b0;
    if (mw) begin
      StallPC = 1'b1;
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      StallM  = 1'b1;
    end else if (PCSrcE) begin
      FlushF = 1'b1;
      FlushD = 1'b1;
    end else if (lu) begin
      StallPC = 1'b1;
      StallF  = 1'b1;
      FlushD  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wd_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wd_cnt <= '0;
          if (MemAccessM && !mem_ready)
            state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state  <= RUN;
            wd_cnt <= '0;
          end else if (to_release) begin
            state       <= RUN;
            wd_cnt      <= '0;
            mem_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state  <= RUN;
          wd_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (StallPC && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (FlushF && (flush_events != '1))
        flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table for combinational rules,
// hand sequences for memory wait, watchdog release and reset.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallPC, StallF, StallD, StallE, StallM, FlushF, FlushD;
  logic       mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events;
  int unsigned exp_stall_cnt, exp_flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [4:0] r1d, r2d, r1e, r2e, rde, rdm, rdw;
    logic [1:0] rsrc;
    logic       rwm, rww, pc, mem, rdy;
    logic [11:0] exp;  // {fa, fb, stall PC/F/D/E/M, flush F/D, timeout}
  } vec_t;

  logic [11:0] sb_q[$];
  vec_t        tbl[$];

  always #5 clk = ~clk;

  hazard_unit #(.TO_WIDTH(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .mem_ready(mem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallPC(StallPC), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushF(FlushF), .FlushD(FlushD),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .mem_timeout(mem_timeout)
  );

  function automatic vec_t mkv(string n,
      logic [4:0] r1d, logic [4:0] r2d, logic [4:0] r1e, logic [4:0] r2e,
      logic [4:0] rde, logic [4:0] rdm, logic [4:0] rdw, logic [1:0] rsrc,
      logic rwm, logic rww, logic pc, logic mem, logic rdy,
      logic [1:0] fa, logic [1:0] fb, logic [4:0] st, logic [1:0] fl, logic to);
    vec_t v;
    v.name = n;
    v.r1d = r1d; v.r2d = r2d; v.r1e = r1e; v.r2e = r2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rsrc = rsrc;
    v.rwm = rwm; v.rww = rww; v.pc = pc; v.mem = mem; v.rdy = rdy;
    v.exp = {fa, fb, st, fl, to};
    return v;
  endfunction

  function automatic logic [11:0] actual();
    return {ForwardAE, ForwardBE, StallPC, StallF, StallD, StallE, StallM,
            FlushF, FlushD, mem_timeout};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rs1D = v.r1d; rs2D = v.r2d; rs1E = v.r1e; rs2E = v.r2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw; ResultSrcE = v.rsrc;
    RegWriteM = v.rwm; RegWriteW = v.rww; PCSrcE = v.pc;
    MemAccessM = v.mem; mem_ready = v.rdy;
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance.
  task automatic step(vec_t v);
    logic [11:0] e;
    drive(v);
    sb_q.push_back(v.exp);
    @(negedge clk);
    e = sb_q.pop_front();
    check(v.name, {20'd0, actual()}, {20'd0, e});
    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_EN
    if (e[7]) exp_stall_cnt++;
    if (e[2]) exp_flush_cnt++;
`endif
  endtask

  task automatic do_reset(string name);
    logic [11:0] e;
    drive(mkv("", 0,0,0,0,0,0,0, 2'b00, 0,0,0,0,0, 0,0,0,0,0));
    rst_n = 1'b0;
    sb_q.push_back(12'd0);
    @(negedge clk);
    e = sb_q.pop_front();
    check(name, {20'd0, actual()}, {20'd0, e});
`ifdef HAZARD_PERF_EN
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
    check({name, "_perf"}, stall_cycles | flush_events, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0;
    drive(mkv("", 0,0,0,0,0,0,0, 2'b00, 0,0,0,0,0, 0,0,0,0,0));
    #2;
    do_reset("reset_state");

    //                r1d r2d r1e r2e rde rdm rdw rsrc  rwm rww pc mem rdy  fa     fb     stall     flush  to
    tbl.push_back(mkv("fwdA_M_prio", 0,0, 5,0, 0, 5,5, 2'b00, 1,1,0,0,0, 2'b10,2'b00,5'b00000,2'b00,0));
    tbl.push_back(mkv("fwdA_W",      0,0, 5,0, 0, 5,5, 2'b00, 0,1,0,0,0, 2'b01,2'b00,5'b00000,2'b00,0));
    tbl.push_back(mkv("fwdA_rd0",    0,0, 5,0, 0, 0,0, 2'b00, 1,1,0,0,0, 2'b00,2'b00,5'b00000,2'b00,0));
    tbl.push_back(mkv("fwd_x0",      0,0, 0,0, 0, 0,0, 2'b00, 1,1,0,0,0, 2'b00,2'b00,5'b00000,2'b00,0));
    tbl.push_back(mkv("fwdB_M_A_W",  0,0, 3,9, 0, 9,3, 2'b00, 1,1,0,0,0, 2'b01,2'b10,5'b00000,2'b00,0));
    tbl.push_back(mkv("fwdB_W",      0,0, 1,4, 0, 4,4, 2'b00, 0,1,0,0,0, 2'b00,2'b01,5'b00000,2'b00,0));
    tbl.push_back(mkv("lu_rs2",      0,7, 0,0, 7, 0,0, 2'b01, 0,0,0,0,0, 2'b00,2'b00,5'b11000,2'b01,0));
    tbl.push_back(mkv("lu_bubble",   0,7, 0,0, 0, 0,0, 2'b00, 0,0,0,0,0, 2'b00,2'b00,5'b00000,2'b00,0));
    tbl.push_back(mkv("lu_rs1",     12,3, 0,0,12, 0,0, 2'b01, 0,0,0,0,0, 2'b00,2'b00,5'b11000,2'b01,0));
    tbl.push_back(mkv("lu_rd0",      0,0, 0,0, 0, 0,0, 2'b01, 0,0,0,0,0, 2'b00,2'b00,5'b00000,2'b00,0));
    tbl.push_back(mkv("no_load",     0,7, 0,0, 7, 0,0, 2'b10, 0,0,0,0,0, 2'b00,2'b00,5'b00000,2'b00,0));
    tbl.push_back(mkv("br_over_lu",  0,7, 0,0, 7, 0,0, 2'b01, 0,0,1,0,0, 2'b00,2'b00,5'b00000,2'b11,0));
    tbl.push_back(mkv("branch",      0,0, 0,0, 0, 0,0, 2'b00, 0,0,1,0,0, 2'b00,2'b00,5'b00000,2'b11,0));
    tbl.push_back(mkv("mem_hit",     0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,1,1, 2'b00,2'b00,5'b00000,2'b00,0));
    foreach (tbl[i]) step(tbl[i]);

    // Three-cycle wait with a taken branch held in E throughout.
    for (int i = 0; i < 3; i++)
      step(mkv("wait3_br", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,1,1,0, 2'b00,2'b00,5'b11111,2'b00,0));
    step(mkv("wait3_rel", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,1,1,1, 2'b00,2'b00,5'b00000,2'b11,0));
    step(mkv("wait3_after", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,0,0, 2'b00,2'b00,5'b00000,2'b00,0));

    // Load-use and forwarding during a wait; load-use acts on release.
    step(mkv("wait_lu", 0,7, 6,0, 7, 6,0, 2'b01, 1,0,0,1,0, 2'b10,2'b00,5'b11111,2'b00,0));
    step(mkv("wait_lu", 0,7, 6,0, 7, 6,0, 2'b01, 1,0,0,1,0, 2'b10,2'b00,5'b11111,2'b00,0));
    step(mkv("wait_lu_rel", 0,7, 6,0, 7, 6,0, 2'b01, 1,0,0,1,1, 2'b10,2'b00,5'b11000,2'b01,0));

    // Watchdog release after MEM_TIMEOUT=4 stalled cycles.
    do_reset("reset_pre_to");
    for (int i = 0; i < 4; i++)
      step(mkv("to_wait", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,1,0, 2'b00,2'b00,5'b11111,2'b00,0));
    step(mkv("to_release", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,1,0, 2'b00,2'b00,5'b00000,2'b00,0));
    step(mkv("to_sticky", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,0,0, 2'b00,2'b00,5'b00000,2'b00,1));
    step(mkv("to_sticky_br", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,1,0,0, 2'b00,2'b00,5'b00000,2'b11,1));
    step(mkv("to_sticky2", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,0,0, 2'b00,2'b00,5'b00000,2'b00,1));
`ifdef HAZARD_PERF_EN
    check("perf_stall_cycles", stall_cycles, exp_stall_cnt);
    check("perf_flush_events", flush_events, exp_flush_cnt);
`endif
    do_reset("reset_clears_to");
    step(mkv("to_cleared", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,0,0, 2'b00,2'b00,5'b00000,2'b00,0));

    // Reset in the middle of a wait returns straight to RUN.
    step(mkv("rst_wait", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,1,0, 2'b00,2'b00,5'b11111,2'b00,0));
    step(mkv("rst_wait", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,1,0, 2'b00,2'b00,5'b11111,2'b00,0));
    do_reset("reset_mid_wait");
    step(mkv("post_rst_run", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,0,0, 2'b00,2'b00,5'b00000,2'b00,0));
    for (int i = 0; i < 4; i++)
      step(mkv("post_rst_wait", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,1,0, 2'b00,2'b00,5'b11111,2'b00,0));
    step(mkv("post_rst_to", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,1,0, 2'b00,2'b00,5'b00000,2'b00,0));
    step(mkv("post_rst_flag", 0,0, 0,0, 0, 0,0, 2'b00, 0,0,0,0,0, 2'b00,2'b00,5'b00000,2'b00,1));

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
